// File: rtl/result_checker_if.sv
// Vector/verdict bus between a stimulus source (master) and the result checker (slave).
// Carries the operands, the DUT answers under check, and the registered verdict/counters.
interface result_checker_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       problem_a;
  logic [3:0]       solution_a;
  logic [15:0]      problem_b_1;
  logic [15:0]      problem_b_2;
  logic [16:0]      solution_b;
  logic             done;
  logic             pass;
  logic             err_a;
  logic             err_b;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] fail_count;

  modport master (
    output in_valid, problem_a, solution_a, problem_b_1, problem_b_2, solution_b,
    input  in_ready, done, pass, err_a, err_b, vec_count, fail_count
  );

  modport slave (
    input  in_valid, problem_a, solution_a, problem_b_1, problem_b_2, solution_b,
    output in_ready, done, pass, err_a, err_b, vec_count, fail_count
  );
endinterface

// File: rtl/result_checker.sv
// Bit-serial checker: recomputes popcount(problem_a) and problem_b_1+problem_b_2 one bit
// per cycle, compares against the supplied solutions and keeps saturating tallies.
module result_checker #(
  parameter bit SIGNED_INPUT = 1'b0,
  parameter int CNT_W        = 8
) (
  input  logic           clk,
  input  logic           reset,
  result_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, CMP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       a_q, a_d;
  logic [3:0]       sol_a_q, sol_a_d;
  logic [15:0]      b1_q, b1_d;
  logic [15:0]      b2_q, b2_d;
  logic [16:0]      sol_b_q, sol_b_d;
  logic [3:0]       pop_q, pop_d;
  logic [16:0]      sum_q, sum_d;
  logic             c_q, c_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_a_q, err_a_d;
  logic             err_b_q, err_b_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  logic bit_a, bit_b1, bit_b2, bit_s, bit_c;
  logic mis_a, mis_b;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    sol_a_d    = sol_a_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    sol_b_d    = sol_b_q;
    pop_d      = pop_q;
    sum_d      = sum_q;
    c_d        = c_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_a_d    = err_a_q;
    err_b_d    = err_b_q;
    vec_d      = vec_q;
    fail_d     = fail_q;
    bit_a      = 1'b0;
    bit_b1     = 1'b0;
    bit_b2     = 1'b0;
    bit_s      = 1'b0;
    bit_c      = 1'b0;
    mis_a      = 1'b0;
    mis_b      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.problem_a;
          sol_a_d = bus.solution_a;
          b1_d    = bus.problem_b_1;
          b2_d    = bus.problem_b_2;
          sol_b_d = bus.solution_b;
          pop_d   = 4'd0;
          sum_d   = 17'd0;
          c_d     = 1'b0;
          idx_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // problem_a only has 8 bits, so upper indices contribute nothing to popcount
        bit_a  = idx_q[3] ? 1'b0 : a_q[idx_q[2:0]];
        bit_b1 = b1_q[idx_q];
        bit_b2 = b2_q[idx_q];
        bit_s  = bit_b1 ^ bit_b2 ^ c_q;
        bit_c  = (bit_b1 & bit_b2) | (bit_b1 & c_q) | (bit_b2 & c_q);
        pop_d  = pop_q + {3'b000, bit_a};
        sum_d[idx_q] = bit_s;
        c_d    = bit_c;
        if (idx_q == 4'd15) begin
          // signed operands: bit 16 is the sign extension of bit 15, not the carry-out
          sum_d[16] = SIGNED_INPUT ? bit_s : bit_c;
          state_d   = CMP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      CMP: begin
        mis_a   = (pop_q != sol_a_q);
        mis_b   = (sum_q != sol_b_q);
        err_a_d = mis_a;
        err_b_d = mis_b;
        pass_d  = !mis_a && !mis_b;
        done_d  = 1'b1;
        vec_d   = (vec_q == {CNT_W{1'b1}}) ? vec_q : vec_q + CNT_ONE;
        if (mis_a || mis_b)
          fail_d = (fail_q == {CNT_W{1'b1}}) ? fail_q : fail_q + CNT_ONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      a_q        <= 8'd0;
      sol_a_q    <= 4'd0;
      b1_q       <= 16'd0;
      b2_q       <= 16'd0;
      sol_b_q    <= 17'd0;
      pop_q      <= 4'd0;
      sum_q      <= 17'd0;
      c_q        <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      vec_q      <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      sol_a_q    <= sol_a_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      sol_b_q    <= sol_b_d;
      pop_q      <= pop_d;
      sum_q      <= sum_d;
      c_q        <= c_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      vec_q      <= vec_d;
      fail_q     <= fail_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_a      = err_a_q;
  assign bus.err_b      = err_b_q;
  assign bus.vec_count  = vec_q;
  assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench: three checkers (unsigned/8-bit, signed/8-bit, unsigned/2-bit counters)
// share one stimulus stream; expected verdicts are queued at handshake and popped on done.
module tb_result_checker;

  logic clk;
  logic reset;

  logic        tb_valid;
  logic [7:0]  tb_a;
  logic [3:0]  tb_sa;
  logic [15:0] tb_b1;
  logic [15:0] tb_b2;
  logic [16:0] tb_sb;

  result_checker_if #(.CNT_W(8)) if0 ();
  result_checker_if #(.CNT_W(8)) if1 ();
  result_checker_if #(.CNT_W(2)) if2 ();

  assign if0.in_valid = tb_valid;  assign if1.in_valid = tb_valid;  assign if2.in_valid = tb_valid;
  assign if0.problem_a = tb_a;     assign if1.problem_a = tb_a;     assign if2.problem_a = tb_a;
  assign if0.solution_a = tb_sa;   assign if1.solution_a = tb_sa;   assign if2.solution_a = tb_sa;
  assign if0.problem_b_1 = tb_b1;  assign if1.problem_b_1 = tb_b1;  assign if2.problem_b_1 = tb_b1;
  assign if0.problem_b_2 = tb_b2;  assign if1.problem_b_2 = tb_b2;  assign if2.problem_b_2 = tb_b2;
  assign if0.solution_b = tb_sb;   assign if1.solution_b = tb_sb;   assign if2.solution_b = tb_sb;

  result_checker #(.SIGNED_INPUT(1'b0), .CNT_W(8)) dut_u (.clk(clk), .reset(reset), .bus(if0));
  result_checker #(.SIGNED_INPUT(1'b1), .CNT_W(8)) dut_s (.clk(clk), .reset(reset), .bus(if1));
  result_checker #(.SIGNED_INPUT(1'b0), .CNT_W(2)) dut_c (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  sa;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [16:0] sb;
    logic        ea;
    logic        ebu;
    logic        ebs;
  } vec_t;

  typedef struct {
    logic       ea;
    logic       eb;
    logic       p;
    logic [7:0] vc;
    logic [7:0] fc;
  } exp_t;

  vec_t vt [6];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  int   mvec  [3];
  int   mfail [3];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_in(input int vi, input logic v);
    tb_valid = v;
    tb_a  = vt[vi].a;
    tb_sa = vt[vi].sa;
    tb_b1 = vt[vi].b1;
    tb_b2 = vt[vi].b2;
    tb_sb = vt[vi].sb;
  endtask

  task automatic push_all(input int vi);
    exp_t e;
    int   mx;
    for (int id = 0; id < 3; id++) begin
      mx   = (id == 2) ? 3 : 255;
      e.ea = vt[vi].ea;
      e.eb = (id == 1) ? vt[vi].ebs : vt[vi].ebu;
      e.p  = !e.ea && !e.eb;
      if (mvec[id] < mx) mvec[id]++;
      if (!e.p && mfail[id] < mx) mfail[id]++;
      e.vc = 8'(mvec[id]);
      e.fc = 8'(mfail[id]);
      case (id)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
      $display("issue vec%0d -> dut%0d exp err_a=%0d err_b=%0d pass=%0d vc=%0d fc=%0d",
               vi, id, e.ea, e.eb, e.p, e.vc, e.fc);
    end
  endtask

  task automatic send(input int vi, input bit push_exp, input bit chk_lat);
    int t;
    int lat;
    t = 0;
    @(negedge clk);
    while (!if0.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(t < 40), 32'd1);
    set_in(vi, 1'b1);
    @(posedge clk);
    if (push_exp) push_all(vi);
    @(negedge clk);
    tb_valid = 1'b0;
    if (chk_lat) begin
      lat = 0;
      while (lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
        if (if0.done) break;
      end
      chk("latency", 32'(lat), 32'd17);
      chk("ready_with_done", 32'(if0.in_ready), 32'd1);
    end
  endtask

  task automatic mon(input int id, input logic ea, input logic eb, input logic p,
                     input logic [7:0] vc, input logic [7:0] fc);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      chk($sformatf("unexpected_done_dut%0d", id), 32'd1, 32'd0);
    end else begin
      case (id)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      $display("done dut%0d err_a=%0d err_b=%0d pass=%0d vc=%0d fc=%0d", id, ea, eb, p, vc, fc);
      chk($sformatf("err_a_dut%0d", id), 32'(ea), 32'(e.ea));
      chk($sformatf("err_b_dut%0d", id), 32'(eb), 32'(e.eb));
      chk($sformatf("pass_dut%0d", id), 32'(p), 32'(e.p));
      chk($sformatf("vec_count_dut%0d", id), 32'(vc), 32'(e.vc));
      chk($sformatf("fail_count_dut%0d", id), 32'(fc), 32'(e.fc));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (if0.done) mon(0, if0.err_a, if0.err_b, if0.pass, if0.vec_count, if0.fail_count);
      if (if1.done) mon(1, if1.err_a, if1.err_b, if1.pass, if1.vec_count, if1.fail_count);
      if (if2.done) mon(2, if2.err_a, if2.err_b, if2.pass, {6'd0, if2.vec_count}, {6'd0, if2.fail_count});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vt[0] = '{a: 8'h10, sa: 4'd1, b1: 16'd5,     b2: 16'd127, sb: 17'd132,    ea: 0, ebu: 0, ebs: 0};
    vt[1] = '{a: 8'hA7, sa: 4'd5, b1: 16'd456,   b2: 16'd123, sb: 17'd579,    ea: 0, ebu: 0, ebs: 0};
    vt[2] = '{a: 8'hA7, sa: 4'd4, b1: 16'd456,   b2: 16'd123, sb: 17'd579,    ea: 1, ebu: 0, ebs: 0};
    vt[3] = '{a: 8'h00, sa: 4'd0, b1: 16'hFFFF,  b2: 16'h0001, sb: 17'h10000, ea: 0, ebu: 0, ebs: 1};
    vt[4] = '{a: 8'h00, sa: 4'd0, b1: 16'hFFFF,  b2: 16'h0001, sb: 17'h00000, ea: 0, ebu: 1, ebs: 0};
    vt[5] = '{a: 8'hFF, sa: 4'd0, b1: 16'd1,     b2: 16'd1,    sb: 17'd0,     ea: 1, ebu: 1, ebs: 1};
    for (int i = 0; i < 3; i++) begin
      mvec[i]  = 0;
      mfail[i] = 0;
    end

    reset = 1'b1;
    set_in(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_pass", 32'(if0.pass), 32'd0);
    chk("rst_err", 32'({if0.err_a, if0.err_b}), 32'd0);
    chk("rst_vec", 32'(if0.vec_count), 32'd0);
    chk("rst_fail", 32'(if2.fail_count), 32'd0);
    reset = 1'b0;

    // directed vectors, back to back
    for (int vi = 0; vi < 5; vi++) begin
      send(vi, 1'b1, 1'b1);
      if (vi == 2) begin
        repeat (5) @(posedge clk);
        #1;
        chk("hold_err_a", 32'(if0.err_a), 32'd1);
        chk("hold_pass", 32'(if0.pass), 32'd0);
      end
    end

    // in_valid held high with new data every cycle: only edges 0 and 18 are handshakes
    t = 0;
    @(negedge clk);
    while (!if0.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 36; k++) begin
      if (k > 0) @(negedge clk);
      set_in((k == 0) ? 0 : (k == 18) ? 1 : 5, 1'b1);
      @(posedge clk);
      if (k == 0) push_all(0);
      if (k == 18) push_all(1);
      if (k == 5) begin
        #1;
        chk("busy_not_ready", 32'(if0.in_ready), 32'd0);
      end
    end
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (20) @(posedge clk);

    // reset in the middle of RUN abandons the check
    send(0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("midrst_done", 32'(if0.done), 32'd0);
    chk("midrst_vec", 32'(if0.vec_count), 32'd0);
    chk("midrst_fail", 32'(if0.fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mvec[i]  = 0;
      mfail[i] = 0;
    end
    repeat (25) @(posedge clk);
    #1;
    chk("midrst_vec_after", 32'(if0.vec_count), 32'd0);

    // five failing vectors: the 2-bit counters must stick at 3
    for (int n = 0; n < 5; n++) send(2, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_vec_hold", 32'(if2.vec_count), 32'd3);
    chk("sat_fail_hold", 32'(if2.fail_count), 32'd3);
    chk("wide_vec", 32'(if0.vec_count), 32'd5);

    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter SIGNED_INPUT, default 0: 0 = problem_b operands unsigned; 1 = two's-complement, sign-extended to 17 bits.
REQ-002 Parameter CNT_W, default 8: width of the vec_count and fail_count counters.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a stimulus/response vector is present on the inputs.
REQ-007 in_ready  output  1  checker can accept a vector.
REQ-008 problem_a  input  8  popcount operand.
REQ-009 solution_a  input  4  DUT popcount result under check.
REQ-010 problem_b_1, problem_b_2  input  16 each  adder operands.
REQ-011 solution_b  input  17  DUT sum under check.
REQ-012 done  output  1  one-cycle pulse: verdict valid.
REQ-013 pass  output  1  last vector matched on both checks.
REQ-014 err_a, err_b  output  1 each  popcount mismatch and sum mismatch on the last vector.
REQ-015 vec_count, fail_count  output  CNT_W each  vectors checked and vectors failed.

Function
REQ-016 The block SHALL use a three-state FSM: IDLE, RUN, CMP.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 A handshake SHALL occur on an edge where in_valid=1 and in_ready=1.
- At that edge the block SHALL capture all five data inputs.
- It SHALL clear the popcount accumulator (4 bits), the sum register (17 bits) and the carry.
- It SHALL set bit index i=0 and enter RUN.
REQ-019 In RUN the block SHALL process one bit per cycle, i = 0..15:
- popcount += problem_a[i] when i<8;
- sum[i] = b1[i]^b2[i]^c;
- c = majority(b1[i], b2[i], c).
REQ-020 On the edge processing i=15, the block SHALL set sum[16] and enter CMP.
- SIGNED_INPUT=0: sum[16] = final carry-out.
- SIGNED_INPUT=1: sum[16] = b1[15]^b2[15]^c15, where c15 is the carry into bit 15.
REQ-021 On the edge leaving CMP, the block SHALL register the verdict:
- err_a = (popcount != captured solution_a);
- err_b = (sum != captured solution_b);
- pass = !err_a && !err_b;
- done = 1 for exactly one cycle;
- increment vec_count; increment fail_count if !pass;
- return to IDLE.
REQ-022 Latency: if handshake is edge E0, done SHALL be high in the cycle following edge E17.
- in_ready SHALL be high in that same cycle.
- Throughput SHALL be one vector per 18 cycles.
REQ-023 in_valid while not in IDLE SHALL be ignored; captured operands SHALL NOT change mid-check.
REQ-024 A new handshake on the first IDLE cycle SHALL be accepted while done is high; done SHALL then fall.
REQ-025 pass, err_a and err_b SHALL hold their value until the next verdict.
REQ-026 Counters SHALL saturate at all-ones and SHALL NOT wrap; vec_count SHALL count saturated-case vectors normally until it saturates.

Reset
REQ-027 reset=1 SHALL force, asynchronously:
- state IDLE, in_ready=1;
- done, pass, err_a, err_b = 0;
- vec_count, fail_count, accumulators and index = 0.
REQ-028 Reset asserted during RUN or CMP SHALL abandon the check with no done pulse and no counter update.
REQ-029 The first handshake after reset deassertion SHALL be taken on the first rising edge where in_valid=1.

Verification
REQ-030 a=8'd16, sol_a=1, b1=5, b2=127, sol_b=132 -> done 17 edges after handshake, pass=1, vec_count=1, fail_count=0.
REQ-031 a=8'hA7, sol_a=5, b1=456, b2=123, sol_b=579 -> pass=1; repeat with sol_a=4 -> err_a=1, err_b=0, fail_count=1.
REQ-032 Edge sum: b1=16'hFFFF, b2=16'h0001.
- SIGNED_INPUT=0, sol_b=17'h10000 -> pass=1.
- SIGNED_INPUT=1, sol_b=17'h00000 -> pass=1.
- SIGNED_INPUT=1, sol_b=17'h10000 -> err_b=1.
REQ-033 in_valid held high continuously with new data each cycle -> exactly one vector captured per 18 cycles; the vectors presented while busy are not checked.
REQ-034 reset pulsed on cycle 8 of RUN -> no done pulse, counters 0, in_ready=1 immediately.
REQ-035 With CNT_W=2, check 5 failing vectors -> vec_count=3 and fail_count=3, holding at 3.
